// File: rtl/keypad_pkg.sv
// Shared helpers and state types for the matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        VALID,
        GAP
    } ev_state_e;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int key_idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/keypad_first_set.sv
// Combinational priority encoder: lowest set bit index plus found flag.
module keypad_first_set
    import keypad_pkg::*;
#(
    parameter  int N = 16,
    localparam int W = clog2_min1(N)
) (
    input  logic [N-1:0] i_vec,
    output logic [W-1:0] o_idx,
    output logic         o_found
);

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx   = W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: synchronised rows, per-column settle,
// multi-scan debounce and a press/release event stream.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter  int ROWS           = 4,
    parameter  int COLS           = 4,
    parameter  int SETTLE_CYC     = 16,
    parameter  int DEBOUNCE_SCANS = 4,
    localparam int N              = ROWS * COLS,
    localparam int KW             = clog2_min1(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [ROWS-1:0] row,
    output logic [COLS-1:0] col,
    output logic [N-1:0]    buttons,
    output logic            key_valid,
    output logic [KW-1:0]   key_code,
    output logic            key_press,
    input  logic            key_ready
);

    localparam int CW = clog2_min1(COLS);
    localparam int SW = clog2_min1(SETTLE_CYC);
    localparam int DW = clog2_min1(DEBOUNCE_SCANS + 1);

    logic [ROWS-1:0] r_sync1;
    logic [ROWS-1:0] r_sync2;
    logic            r_run;
    logic [CW-1:0]   r_cidx;
    logic [SW-1:0]   r_cnt;
    logic [N-1:0]    r_scan;
    logic [N-1:0]    r_prev;
    logic [DW-1:0]   r_stable;
    logic [N-1:0]    r_buttons;
    logic [N-1:0]    r_rep;
    logic [KW-1:0]   r_code;
    logic            r_press;
    ev_state_e       r_state;
    ev_state_e       w_next;

    logic            w_sample;
    logic            w_scan_end;
    logic [N-1:0]    w_scan_next;
    logic [N-1:0]    w_diff;
    logic [KW-1:0]   w_idx;
    logic            w_found;
    logic            w_load;
    logic            w_accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= row;
            r_sync2 <= r_sync1;
        end
    end

    // r_run delays counting by one cycle so column 0 gets a full settle window
    assign w_sample   = r_run && en && (r_cnt == SW'(SETTLE_CYC - 1));
    assign w_scan_end = w_sample && (r_cidx == CW'(COLS - 1));
    assign col        = r_run ? ~(COLS'(1) << r_cidx) : '1;

    always_comb begin
        w_scan_next = r_scan;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (CW'(c) == r_cidx) begin
                    w_scan_next[key_idx(r, c, COLS)] = ~r_sync2[r];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run    <= 1'b0;
            r_cidx   <= '0;
            r_cnt    <= '0;
            r_scan   <= '0;
            r_prev   <= '0;
            r_stable <= '0;
        end else if (!en) begin
            r_run    <= 1'b0;
            r_cidx   <= '0;
            r_cnt    <= '0;
            r_stable <= '0;
        end else if (!r_run) begin
            r_run <= 1'b1;
        end else if (w_sample) begin
            r_cnt  <= '0;
            r_scan <= w_scan_next;
            r_cidx <= (r_cidx == CW'(COLS - 1)) ? '0 : r_cidx + 1'b1;
            if (w_scan_end) begin
                r_prev <= w_scan_next;
                if (w_scan_next != r_prev) begin
                    r_stable <= DW'(1);
                end else if (r_stable != DW'(DEBOUNCE_SCANS)) begin
                    r_stable <= r_stable + 1'b1;
                end
            end
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buttons <= '0;
        end else if (r_stable == DW'(DEBOUNCE_SCANS)) begin
            r_buttons <= r_prev;
        end
    end

    assign w_diff = r_buttons ^ r_rep;

    keypad_first_set #(
        .N(N)
    ) u_first_set (
        .i_vec  (w_diff),
        .o_idx  (w_idx),
        .o_found(w_found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_accept = 1'b0;
        unique case (r_state)
            IDLE, GAP: begin
                w_next = w_found ? VALID : IDLE;
                w_load = w_found;
            end
            VALID: begin
                if (key_ready) begin
                    w_next   = GAP;
                    w_accept = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep   <= '0;
            r_code  <= '0;
            r_press <= 1'b0;
        end else begin
            if (w_load) begin
                r_code  <= w_idx;
                r_press <= r_buttons[w_idx];
            end
            if (w_accept) begin
                r_rep[r_code] <= r_press;
            end
        end
    end

    assign buttons   = r_buttons;
    assign key_valid = (r_state == VALID);
    assign key_code  = r_code;
    assign key_press = r_press;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: 4x3 grid, settle 4, debounce 3.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  row;
    logic [2:0]  col;
    logic [11:0] buttons;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_press;
    logic        key_ready = 1'b0;

    logic [11:0] keys = '0;
    logic [4:0]  ev_q[$];
    int          vcnt = 0;
    int          total = 0;
    int          bad = 0;

    keypad_scanner #(
        .ROWS(4),
        .COLS(3),
        .SETTLE_CYC(4),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .row      (row),
        .col      (col),
        .buttons  (buttons),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_press(key_press),
        .key_ready(key_ready)
    );

    always #5 clk = ~clk;

    // Keypad model: a pressed key pulls its row low while its column is driven
    always_comb begin
        row = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (keys[r*3+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (key_valid && key_ready) ev_q.push_back({key_press, key_code});
        if (key_valid) vcnt <= vcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ev_at(input int i);
        return (ev_q.size() > i) ? {27'd0, ev_q[i]} : 32'hffff;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        repeat (2) @(negedge clk);
        chk("rst_col", col, 3'b111);
        chk("rst_buttons", buttons, 0);
        chk("rst_valid", key_valid, 0);
        chk("rst_code", key_code, 0);
        chk("rst_press", key_press, 0);

        rst = 1'b0;
        en  = 1'b1;
        @(negedge clk);
        chk("col0_first", col, 3'b110);
        repeat (3) @(negedge clk);
        chk("col0_last", col, 3'b110);
        @(negedge clk);
        chk("col1", col, 3'b101);
        repeat (4) @(negedge clk);
        chk("col2", col, 3'b011);
        repeat (4) @(negedge clk);
        chk("col_wrap", col, 3'b110);
        chk("idle_buttons", buttons, 0);
        chk("idle_valid", key_valid, 0);

        // single key press and release, consumer always ready
        key_ready = 1'b1;
        keys[5] = 1'b1;
        v0 = vcnt;
        for (int i = 0; i < 60 && !buttons[5]; i++) @(negedge clk);
        chk("press5_btn", buttons, 12'h020);
        repeat (10) @(negedge clk);
        chk("press5_nev", ev_q.size(), 1);
        chk("press5_ev", ev_at(0), {1'b1, 4'd5});
        chk("press5_vcyc", vcnt - v0, 1);
        keys[5] = 1'b0;
        for (int i = 0; i < 60 && buttons[5]; i++) @(negedge clk);
        chk("rel5_btn", buttons, 0);
        repeat (10) @(negedge clk);
        chk("rel5_ev", ev_at(1), {1'b0, 4'd5});

        // bouncing key on alternate scans never settles
        for (int s = 0; s < 10; s++) begin
            keys[0] = (s % 2 == 0);
            repeat (12) @(negedge clk);
            chk("bounce_btn", buttons, 0);
        end
        keys[0] = 1'b0;
        repeat (40) @(negedge clk);
        chk("bounce_btn_end", buttons, 0);
        chk("bounce_nev", ev_q.size(), 2);
        chk("bounce_valid", key_valid, 0);

        // two keys together, consumer stalled
        key_ready = 1'b0;
        keys[1] = 1'b1;
        keys[9] = 1'b1;
        for (int i = 0; i < 70 && !key_valid; i++) @(negedge clk);
        chk("dual_valid", key_valid, 1);
        chk("dual_code", key_code, 1);
        chk("dual_press", key_press, 1);
        chk("dual_btn", buttons, 12'h202);
        repeat (5) @(negedge clk);
        chk("dual_hold_v", key_valid, 1);
        chk("dual_hold_c", key_code, 1);
        key_ready = 1'b1;
        @(negedge clk);
        chk("dual_gap", key_valid, 0);
        @(negedge clk);
        chk("dual2_valid", key_valid, 1);
        chk("dual2_code", key_code, 9);
        chk("dual2_press", key_press, 1);
        repeat (3) @(negedge clk);
        chk("dual_ev1", ev_at(2), {1'b1, 4'd1});
        chk("dual_ev9", ev_at(3), {1'b1, 4'd9});
        keys[1] = 1'b0;
        keys[9] = 1'b0;
        for (int i = 0; i < 60 && buttons != 0; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        chk("dual_rel1", ev_at(4), {1'b0, 4'd1});
        chk("dual_rel9", ev_at(5), {1'b0, 4'd9});

        // key changes and reverts before its event is accepted
        key_ready = 1'b0;
        keys[8] = 1'b1;
        for (int i = 0; i < 70 && !key_valid; i++) @(negedge clk);
        chk("stale_code", key_code, 8);
        chk("stale_press", key_press, 1);
        keys[8] = 1'b0;
        for (int i = 0; i < 60 && buttons[8]; i++) @(negedge clk);
        chk("stale_btn", buttons, 0);
        chk("stale_hold_v", key_valid, 1);
        chk("stale_hold_c", key_code, 8);
        chk("stale_hold_p", key_press, 1);
        key_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("stale_ev_p", ev_at(6), {1'b1, 4'd8});
        chk("stale_ev_r", ev_at(7), {1'b0, 4'd8});
        chk("stale_nev", ev_q.size(), 8);

        // disable, then async reset mid-scan with an event pending
        key_ready = 1'b0;
        keys[4] = 1'b1;
        for (int i = 0; i < 70 && !key_valid; i++) @(negedge clk);
        chk("pend_valid", key_valid, 1);
        en = 1'b0;
        @(negedge clk);
        chk("dis_col", col, 3'b111);
        chk("dis_btn", buttons, 12'h010);
        en = 1'b1;
        for (int i = 0; i < 20 && col != 3'b101; i++) @(negedge clk);
        chk("mid_col1", col, 3'b101);
        rst = 1'b1;
        #1;
        chk("arst_col", col, 3'b111);
        chk("arst_valid", key_valid, 0);
        chk("arst_btn", buttons, 0);
        chk("arst_code", key_code, 0);
        keys[4] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        key_ready = 1'b1;
        repeat (80) @(negedge clk);
        chk("post_nev", ev_q.size(), 8);
        chk("post_btn", buttons, 0);
        chk("post_valid", key_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
